// File: rtl/pm_loader_pkg.sv
// Shared definitions for the program-memory loader and the later BF decode stage:
// FSM state encoding, the eight BF opcodes and the program terminator.
package pm_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TERM  = 2'd2,
        ST_DONE  = 2'd3
    } pm_state_e;

    localparam logic [7:0] OP_INC        = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC        = 8'h2D;  // '-'
    localparam logic [7:0] OP_LEFT       = 8'h3C;  // '<'
    localparam logic [7:0] OP_RIGHT      = 8'h3E;  // '>'
    localparam logic [7:0] OP_LOOP_BEGIN = 8'h5B;  // '['
    localparam logic [7:0] OP_LOOP_END   = 8'h5D;  // ']'
    localparam logic [7:0] OP_OUT        = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN         = 8'h2C;  // ','
    localparam logic [7:0] OP_TERM       = 8'h00;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_INC)  || (b == OP_DEC)        || (b == OP_LEFT) ||
               (b == OP_RIGHT) || (b == OP_LOOP_BEGIN) || (b == OP_LOOP_END) ||
               (b == OP_OUT)  || (b == OP_IN);
    endfunction

endpackage

// File: rtl/pm_loader_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counting debouncer and a
// one-cycle press pulse on each accepted high-to-low transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    // A key held through reset must first be seen released this long before presses count.
    localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 2;
    localparam int CW         = $clog2(ARM_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          key_s;
    logic          stable_q, stable_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] arm_cnt_q, arm_cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    assign key_s   = sync_q[1];
    assign press_o = press_q;

    always_comb begin
        stable_d  = stable_q;
        db_cnt_d  = '0;
        armed_d   = armed_q;
        arm_cnt_d = arm_cnt_q;

        if (key_s != stable_q) begin
            if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + CW'(1);
            end
        end

        if (!armed_q) begin
            if (key_s) begin
                if (arm_cnt_q == CW'(ARM_CYCLES - 1)) begin
                    armed_d = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + CW'(1);
                end
            end else begin
                arm_cnt_d = '0;
            end
        end

        press_d = armed_q & stable_q & ~stable_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            stable_q  <= 1'b1;
            db_cnt_q  <= '0;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
        end
    end

endmodule

// File: rtl/pm_loader.sv
// Switch-driven BF program loader: commits legal opcode bytes into program
// memory on the write key and appends the terminator on the done key.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_write_n,
    input  logic              key_done_n,
    input  logic [7:0]        sw,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [7:0]        pm_wdata,
    output logic              pm_we,
    output logic              loaded,
    output logic              rejected,
    output logic [ADDR_W-1:0] count
);

    localparam logic [ADDR_W-1:0] COUNT_MAX = '1;

    logic [1:0] keys_n;
    logic [1:0] press;

    assign keys_n = {key_done_n, key_write_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk     (clock),
                .rst_n   (reset),
                .key_n_i (keys_n[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    pm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        sw_q, sw_d;
    logic              wr_pend_q, wr_pend_d;
    logic              done_pend_q, done_pend_d;
    logic              rej_q, rej_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rej_d       = 1'b0;
        sw_d        = press[0] ? sw : sw_q;
        wr_pend_d   = wr_pend_q | press[0];
        done_pend_d = done_pend_q | press[1];

        unique case (state_q)
            ST_LOAD: begin
                // Done takes priority; a write registered alongside it is dropped silently.
                if (done_pend_q) begin
                    state_d     = ST_TERM;
                    addr_d      = count_q;
                    wdata_d     = OP_TERM;
                    wr_pend_d   = 1'b0;
                    done_pend_d = 1'b0;
                end else if (wr_pend_q) begin
                    wr_pend_d = press[0];
                    if (is_opcode(sw_q) && (count_q != COUNT_MAX)) begin
                        state_d = ST_WRITE;
                        addr_d  = count_q;
                        wdata_d = sw_q;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + ADDR_W'(1);
                state_d = ST_LOAD;
            end
            ST_TERM: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                wr_pend_d   = 1'b0;
                done_pend_d = 1'b0;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            count_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sw_q        <= '0;
            wr_pend_q   <= 1'b0;
            done_pend_q <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sw_q        <= sw_d;
            wr_pend_q   <= wr_pend_d;
            done_pend_q <= done_pend_d;
            rej_q       <= rej_d;
        end
    end

    assign pm_we    = (state_q == ST_WRITE) || (state_q == ST_TERM);
    assign pm_addr  = addr_q;
    assign pm_wdata = wdata_q;
    assign loaded   = (state_q == ST_DONE);
    assign rejected = rej_q;
    assign count    = count_q;

endmodule

// File: doc/pm_loader.md
PM_LOADER -- requirements
Module: pm_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required before a key change is accepted.
REQ-002 Parameter ADDR_W, default 8: program-memory address width; depth is 2**ADDR_W.
REQ-003 Port clock, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1: asynchronous active-low reset.
REQ-005 Port key_write_n, input, 1: raw push-button (low = pressed) that commits the current switch byte.
REQ-006 Port key_done_n, input, 1: raw push-button (low = pressed) that ends program entry.
REQ-007 Port sw, input, 8: ASCII instruction byte taken from the switches.
REQ-008 Port pm_addr, output, ADDR_W: program-memory write address.
REQ-009 Port pm_wdata, output, 8: program-memory write data.
REQ-010 Port pm_we, output, 1: one-cycle write strobe.
REQ-011 Port loaded, output, 1: level signal; high once the program is terminated; feeds PMInputDone of main.
REQ-012 Port rejected, output, 1: one-cycle pulse when a commit is refused.
REQ-013 Port count, output, ADDR_W: number of instructions stored, excluding the terminator.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES equal samples.
REQ-015 Only the debounced press edge (high-to-low) SHALL generate an event; holding or releasing a key SHALL generate nothing.
REQ-016 The FSM SHALL have states LOAD, WRITE, TERM, DONE.
REQ-017 In LOAD, a write event with sw in the legal set {0x2B '+', 0x2D '-', 0x3C '<', 0x3E '>', 0x5B '[', 0x5D ']', 0x2E '.', 0x2C ','} and count < 2**ADDR_W-1 SHALL transition to WRITE.
REQ-018 WRITE SHALL last one cycle, assert pm_we=1 with pm_addr=count and pm_wdata=the sw byte latched at the event, then increment count and return to LOAD.
REQ-019 A write event with an illegal byte, or with count = 2**ADDR_W-1 (last slot reserved for the terminator), SHALL pulse rejected for one cycle, write nothing, and stay in LOAD.
REQ-020 In LOAD, a done event SHALL transition to TERM; TERM SHALL write 0x00 at pm_addr=count for one cycle, then go to DONE.
REQ-021 If write and done events arrive in the same cycle, done SHALL win and the write SHALL be discarded without a rejected pulse.
REQ-022 DONE SHALL hold loaded=1, ignore all key events, and exit only on reset.
REQ-023 Latency from debounced press edge to pm_we: exactly 2 clock cycles (register the event, then WRITE or TERM).
REQ-024 pm_we SHALL be asserted only in WRITE and TERM; pm_addr and pm_wdata SHALL be registered.
REQ-025 count SHALL never wrap; its maximum is 2**ADDR_W-1.

Reset
REQ-026 Reset low SHALL asynchronously force: state=LOAD, count=0, pm_addr=0, pm_wdata=0, pm_we=0, loaded=0, rejected=0, synchronizers and debouncers to released (high).
REQ-027 Reset asserted during WRITE or TERM SHALL abort the write; the deassertion cycle SHALL NOT emit pm_we.
REQ-028 A key held through reset release SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the eight BF opcode constants, and the terminator constant 0x00; the future decode stage of main reuses them.
REQ-030 The synchronizer and debouncer SHALL be one sub-module, key_debounce, instantiated once per key.

Verification
REQ-031 Reset, press write with sw=0x2B, release -> exactly one pm_we with addr 0x00, data 0x2B; count=1.
REQ-032 Bouncing key_write_n (3 glitches shorter than DEBOUNCE_CYCLES) with sw=0x3E -> exactly one write.
REQ-033 sw=0x41 press -> rejected pulses once, pm_we stays 0, count unchanged.
REQ-034 Commit 255 legal bytes, then press write again -> rejected; press done -> 0x00 written at addr 0xFF, loaded=1.
REQ-035 Write and done pressed in the same cycle after 2 stored bytes -> 0x00 written at addr 0x02, no rejected pulse, loaded=1, later presses ignored.
REQ-036 Reset asserted in the WRITE cycle -> pm_we drops immediately, count=0, loaded=0.
